// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS CPU: decodes the state into datapath
// controls, bounds memory waits, and counts retired instructions.
module multicycle_control #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned WAIT_LIMIT = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [5:0]       op_i,
   input  logic             mem_ready_i,
   input  logic             zero_i,
   output logic             PCWrite_o,
   output logic             PCWriteCond_o,
   output logic             IorD_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             IRWrite_o,
   output logic             MemtoReg_o,
   output logic             RegDst_o,
   output logic             RegWrite_o,
   output logic             ALUSrcA_o,
   output logic [1:0]       ALUSrcB_o,
   output logic [1:0]       ALUOp_o,
   output logic [1:0]       PCSource_o,
   output logic             halted_o,
   output logic             err_o,
   output logic [CNT_W-1:0] instr_cnt_o
);

   localparam int unsigned WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_MEM_ADDR, S_MEM_RD,
      S_LW_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_ADDI_EX, S_ADDI_WB, S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              mem_done, mem_timeout;

   // The branch condition is gated in the datapath, not here.
   logic unused_zero;
   assign unused_zero = zero_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Ready on the last allowed cycle still counts as success.
   assign mem_done    = mem_ready_i;
   assign mem_timeout = !mem_ready_i && (wait_q == WAIT_LAST);

   always_comb begin
      state_d       = state_q;
      wait_d        = '0;
      cnt_d         = cnt_q;
      err_d         = err_q;
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      MemtoReg_o    = 1'b0;
      RegDst_o      = 1'b0;
      RegWrite_o    = 1'b0;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = 2'b00;
      ALUOp_o       = 2'b00;
      PCSource_o    = 2'b00;
      halted_o      = 1'b0;

      if (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) begin
         if (!mem_done && !mem_timeout) wait_d = wait_q + WAIT_W'(1);
         if (mem_timeout) begin
            state_d = S_HALT;
            err_d   = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            MemRead_o = 1'b1;
            ALUSrcB_o = 2'b01;
            if (mem_done) begin
               IRWrite_o = 1'b1;
               PCWrite_o = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcB_o = 2'b11;
            case (op_i)
               OP_R:         state_d = S_EXEC_R;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EX;
               default:      state_d = S_HALT;
            endcase
         end
         S_EXEC_R: begin
            ALUSrcA_o = 1'b1;
            ALUOp_o   = 2'b10;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            RegDst_o   = 1'b1;
            RegWrite_o = 1'b1;
            state_d    = S_FETCH;
            cnt_d      = cnt_q + CNT_W'(1);
         end
         S_MEM_ADDR: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            state_d   = (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            MemRead_o = 1'b1;
            IorD_o    = 1'b1;
            if (mem_done) state_d = S_LW_WB;
         end
         S_LW_WB: begin
            MemtoReg_o = 1'b1;
            RegWrite_o = 1'b1;
            state_d    = S_FETCH;
            cnt_d      = cnt_q + CNT_W'(1);
         end
         S_MEM_WR: begin
            MemWrite_o = 1'b1;
            IorD_o     = 1'b1;
            if (mem_done) begin
               state_d = S_FETCH;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         S_BRANCH: begin
            ALUSrcA_o     = 1'b1;
            ALUOp_o       = 2'b01;
            PCWriteCond_o = 1'b1;
            PCSource_o    = 2'b01;
            state_d       = S_FETCH;
            cnt_d         = cnt_q + CNT_W'(1);
         end
         S_JUMP: begin
            PCWrite_o  = 1'b1;
            PCSource_o = 2'b10;
            state_d    = S_FETCH;
            cnt_d      = cnt_q + CNT_W'(1);
         end
         S_ADDI_EX: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
            state_d   = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            RegWrite_o = 1'b1;
            state_d    = S_FETCH;
            cnt_d      = cnt_q + CNT_W'(1);
         end
         S_HALT: begin
            halted_o = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign err_o       = err_q;
   assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a short wait limit and a 4-bit
// retire counter, so timeout and counter wrap are reachable quickly.
module tb_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   // ctl = {PCW,PCWC,IorD,MR,MW,IRW,M2R,RegDst,RW,SrcA,SrcB[1:0],ALUOp[1:0],PCSrc[1:0]}
   localparam logic [15:0] C_ZERO      = 16'h0000;
   localparam logic [15:0] C_FETCH_W   = 16'h1010;
   localparam logic [15:0] C_FETCH_R   = 16'h9410;
   localparam logic [15:0] C_DECODE    = 16'h0030;
   localparam logic [15:0] C_EXEC_R    = 16'h0048;
   localparam logic [15:0] C_R_WB      = 16'h0180;
   localparam logic [15:0] C_MEM_ADDR  = 16'h0060;
   localparam logic [15:0] C_MEM_RD    = 16'h3000;
   localparam logic [15:0] C_LW_WB     = 16'h0280;
   localparam logic [15:0] C_MEM_WR    = 16'h2800;
   localparam logic [15:0] C_BRANCH    = 16'h4045;
   localparam logic [15:0] C_JUMP      = 16'h8002;
   localparam logic [15:0] C_ADDI_EX   = 16'h0060;
   localparam logic [15:0] C_ADDI_WB   = 16'h0080;

   logic       clk_i = 1'b0;
   logic       rst_i, start_i, mem_ready_i, zero_i;
   logic [5:0] op_i;
   logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
   logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, halted_o, err_o;
   logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o;
   logic [3:0] instr_cnt_o;
   logic [15:0] ctl;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   multicycle_control #(.CNT_W(4), .WAIT_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .mem_ready_i(mem_ready_i), .zero_i(zero_i),
      .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
      .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
      .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
      .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
      .PCSource_o(PCSource_o), .halted_o(halted_o), .err_o(err_o),
      .instr_cnt_o(instr_cnt_o)
   );

   assign ctl = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                 MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
                 PCSource_o};

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; mem_ready_i = 1'b0; op_i = OP_R; zero_i = 1'b0;
      #12;
      check("rst_ctl", 32'(ctl), 32'(C_ZERO));
      check("rst_halted", 32'(halted_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_cnt", 32'(instr_cnt_o), 32'd0);

      // R-type
      rst_i = 1'b0; start_i = 1'b1; mem_ready_i = 1'b1; op_i = OP_R; #1;
      check("idle_ctl", 32'(ctl), 32'(C_ZERO));
      cyc(); start_i = 1'b0; #1;
      check("r_fetch", 32'(ctl), 32'(C_FETCH_R));
      cyc(); check("r_decode", 32'(ctl), 32'(C_DECODE));
      cyc(); check("r_exec", 32'(ctl), 32'(C_EXEC_R));
      check("r_aluop", 32'(ALUOp_o), 32'd2);
      cyc(); check("r_wb", 32'(ctl), 32'(C_R_WB));
      check("r_cnt_pre", 32'(instr_cnt_o), 32'd0);
      cyc(); check("r_back_fetch", 32'(ctl), 32'(C_FETCH_R));
      check("r_cnt", 32'(instr_cnt_o), 32'd1);

      // lw, ready low 3 cycles then high on the limit cycle
      op_i = OP_LW;
      cyc(); check("lw_decode", 32'(ctl), 32'(C_DECODE));
      cyc(); check("lw_addr", 32'(ctl), 32'(C_MEM_ADDR));
      mem_ready_i = 1'b0;
      cyc();
      for (int i = 0; i < 3; i++) begin
         check("lw_wait", 32'(ctl), 32'(C_MEM_RD));
         cyc();
      end
      mem_ready_i = 1'b1; #1;
      check("lw_last", 32'(ctl), 32'(C_MEM_RD));
      check("lw_not_halted", 32'(halted_o), 32'd0);
      cyc(); check("lw_wb", 32'(ctl), 32'(C_LW_WB));
      cyc(); check("lw_cnt", 32'(instr_cnt_o), 32'd2);

      // sw, with two wait cycles in FETCH
      mem_ready_i = 1'b0; op_i = OP_SW; #1;
      check("sw_fetch_w0", 32'(ctl), 32'(C_FETCH_W));
      cyc(); check("sw_fetch_w1", 32'(ctl), 32'(C_FETCH_W));
      mem_ready_i = 1'b1; #1;
      check("sw_fetch_rdy", 32'(ctl), 32'(C_FETCH_R));
      cyc(); cyc(); check("sw_addr", 32'(ctl), 32'(C_MEM_ADDR));
      cyc(); check("sw_mem_wr", 32'(ctl), 32'(C_MEM_WR));
      cyc(); check("sw_cnt", 32'(instr_cnt_o), 32'd3);

      // beq and j
      op_i = OP_BEQ; zero_i = 1'b1;
      cyc(); cyc(); check("beq_branch", 32'(ctl), 32'(C_BRANCH));
      cyc(); check("beq_fetch", 32'(ctl), 32'(C_FETCH_R));
      check("beq_cnt", 32'(instr_cnt_o), 32'd4);
      op_i = OP_J; zero_i = 1'b0;
      cyc(); cyc(); check("j_jump", 32'(ctl), 32'(C_JUMP));
      cyc(); check("j_cnt", 32'(instr_cnt_o), 32'd5);

      // addi
      op_i = OP_ADDI;
      cyc(); cyc(); check("addi_ex", 32'(ctl), 32'(C_ADDI_EX));
      cyc(); check("addi_wb", 32'(ctl), 32'(C_ADDI_WB));
      cyc(); check("addi_cnt", 32'(instr_cnt_o), 32'd6);

      // illegal opcode halts; start ignored; reset recovers
      op_i = OP_BAD;
      cyc(); cyc();
      check("ill_ctl", 32'(ctl), 32'(C_ZERO));
      check("ill_halted", 32'(halted_o), 32'd1);
      check("ill_err", 32'(err_o), 32'd0);
      start_i = 1'b1;
      cyc(); cyc(); start_i = 1'b0; #1;
      check("ill_sticky", 32'(halted_o), 32'd1);
      check("ill_sticky_ctl", 32'(ctl), 32'(C_ZERO));
      check("ill_cnt", 32'(instr_cnt_o), 32'd6);
      rst_i = 1'b1; #1;
      check("ill_rst_halted", 32'(halted_o), 32'd0);
      check("ill_rst_cnt", 32'(instr_cnt_o), 32'd0);
      #3 rst_i = 1'b0;

      // FETCH timeout after 4 cycles
      start_i = 1'b1; mem_ready_i = 1'b0; op_i = OP_R;
      cyc(); start_i = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         check("to_fetch", 32'(ctl), 32'(C_FETCH_W));
         check("to_not_halted", 32'(halted_o), 32'd0);
         cyc();
      end
      check("to_ctl", 32'(ctl), 32'(C_ZERO));
      check("to_halted", 32'(halted_o), 32'd1);
      check("to_err", 32'(err_o), 32'd1);
      rst_i = 1'b1; #1;
      check("to_rst_err", 32'(err_o), 32'd0);
      #3 rst_i = 1'b0;

      // counter wrap with 17 addi, then async reset mid-MEM_WR
      start_i = 1'b1; mem_ready_i = 1'b1; op_i = OP_ADDI;
      cyc(); start_i = 1'b0;
      for (int i = 0; i < 16; i++) repeat (4) cyc();
      check("wrap_16", 32'(instr_cnt_o), 32'd0);
      repeat (4) cyc();
      check("wrap_17", 32'(instr_cnt_o), 32'd1);
      op_i = OP_SW;
      cyc(); cyc(); mem_ready_i = 1'b0;
      cyc(); check("rstwr_memwr", 32'(ctl), 32'(C_MEM_WR));
      rst_i = 1'b1; #1;
      check("rstwr_memwrite", 32'(MemWrite_o), 32'd0);
      check("rstwr_ctl", 32'(ctl), 32'(C_ZERO));
      check("rstwr_cnt", 32'(instr_cnt_o), 32'd0);
      #3 rst_i = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
